// File: rtl/dds_pkg.sv
// Shared constants for the DDS sine generator: default sizes, quadrant codes, pipeline depth.
// Latency: n/a (package).
// Backpressure: n/a (package).
package dds_pkg;

  localparam int PHASE_W_DEF = 16;
  localparam int ADDR_W_DEF  = 7;
  localparam int DATA_W_DEF  = 8;

  // Acceptance-to-out_valid latency of the sample pipeline.
  localparam int PIPE_LAT = 3;

  // Quadrant of the full wave, taken from the top two index bits.
  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_e;

  // Odd quadrants walk the quarter table backwards.
  function automatic logic quad_mirror(input logic [1:0] q);
    return (q == QUAD_1) || (q == QUAD_3);
  endfunction

  // The second half of the wave is the negated first half.
  function automatic logic quad_negate(input logic [1:0] q);
    return (q == QUAD_2) || (q == QUAD_3);
  endfunction

endpackage

// File: rtl/dds_qrom.sv
// Quarter-wave sine magnitude ROM, contents generated at elaboration from the sine formula.
// Latency: 1 cycle, synchronous read.
// Backpressure: rd_en low holds the registered output.
module dds_qrom
  import dds_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-3:0] rd_addr,
  output logic [DATA_W-2:0] rd_dat
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int MAG_W = DATA_W - 1;

  // Entry k samples the first quarter wave at the centre of bin k, so the
  // table never hits exactly zero or full scale and mirroring is exact.
  function automatic int mag_of(input int k);
    real amp;
    real ang;
    amp = real'((2 ** (DATA_W - 1)) - 1);
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(2 ** ADDR_W);
    return int'(amp * $sin(ang));
  endfunction

  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    assign rom[k] = MAG_W'(mag_of(k));
  end

  logic [MAG_W-1:0] rd_dat_q;
  logic [MAG_W-1:0] rd_dat_d;

  // Read port: new word only when the pipeline advances.
  always_comb begin
    rd_dat_d = rd_dat_q;
    if (rd_en) begin
      rd_dat_d = rom[rd_addr];
    end
  end

  // Output register of the synchronous read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_dat_q <= '0;
    end else begin
      rd_dat_q <= rd_dat_d;
    end
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/dds_sine_gen.sv
// Phase-accumulator sine generator using a quarter-wave table with valid/ready output.
// Latency: 3 cycles from acceptance to out_valid; 1 sample/clock sustained.
// Backpressure: out_valid && !out_ready freezes every stage and the accumulator.
module dds_sine_gen
  import dds_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               sync,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [PHASE_W-1:0] phase_ofs,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [1:0]         out_quad
);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0]  s1_idx_q, s1_idx_d;
  logic               s2_vld_q, s2_vld_d;
  logic [1:0]         s2_quad_q, s2_quad_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [1:0]         out_quad_q, out_quad_d;

  logic               advance;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         s1_quad;
  logic [ADDR_W-3:0]  s1_fine;
  logic [ADDR_W-3:0]  rom_addr;
  logic [DATA_W-2:0]  rom_dat;
  logic [DATA_W-1:0]  mag_ext;

  assign advance  = !(out_valid_q && !out_ready);
  assign phase    = acc_q + phase_ofs;
  assign s1_quad  = s1_idx_q[ADDR_W-1 -: 2];
  assign s1_fine  = s1_idx_q[ADDR_W-3:0];
  assign rom_addr = quad_mirror(s1_quad) ? ~s1_fine : s1_fine;
  assign mag_ext  = {1'b0, rom_dat};

  // S2: magnitude lookup, advancing with the rest of the pipeline.
  dds_qrom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_qrom (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (advance),
    .rd_addr (rom_addr),
    .rd_dat  (rom_dat)
  );

  // Next state: sync flushes regardless of backpressure, otherwise shift on advance.
  always_comb begin
    acc_d       = acc_q;
    s1_vld_d    = s1_vld_q;
    s1_idx_d    = s1_idx_q;
    s2_vld_d    = s2_vld_q;
    s2_quad_d   = s2_quad_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_quad_d  = out_quad_q;
    if (sync) begin
      acc_d       = '0;
      s1_vld_d    = 1'b0;
      s2_vld_d    = 1'b0;
      out_valid_d = 1'b0;
    end else if (advance) begin
      s1_vld_d    = en;
      s1_idx_d    = phase[PHASE_W-1 -: ADDR_W];
      if (en) begin
        acc_d = acc_q + freq_word;
      end
      s2_vld_d    = s1_vld_q;
      s2_quad_d   = s1_quad;
      out_valid_d = s2_vld_q;
      out_data_d  = quad_negate(s2_quad_q) ? -mag_ext : mag_ext;
      out_quad_d  = s2_quad_q;
    end
  end

  // Accumulator and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_idx_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_quad_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_quad_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      s1_vld_q    <= s1_vld_d;
      s1_idx_q    <= s1_idx_d;
      s2_vld_q    <= s2_vld_d;
      s2_quad_q   <= s2_quad_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_quad_q  <= out_quad_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_quad  = out_quad_q;

endmodule
